// File: rtl/regfile_write_arbiter_pkg.sv
// Shared register-file definitions for the writeback arbiter and its round-robin picker.
package regfile_write_arbiter_pkg;

    localparam int unsigned REG_ADDR_W = 5;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;

    localparam reg_addr_t ZERO_REG = '0;

    // Width of a pointer able to index n requesters (at least one bit).
    function automatic int unsigned ptr_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/regfile_write_arbiter_rr_priority_pick.sv
// Combinational round-robin pick: first valid requester at or after ptr, modulo N.
module rr_priority_pick #(
    parameter int unsigned N    = 3,
    parameter int unsigned PtrW = 2
) (
    input  logic [N-1:0]    i_req,
    input  logic [PtrW-1:0] i_ptr,
    input  logic            i_stall,
    output logic [N-1:0]    o_grant_onehot,
    output logic [PtrW-1:0] o_grant_idx
);

    int unsigned     w_pos;
    logic [PtrW-1:0] w_pos_idx;
    logic            w_found;

    always_comb begin
        o_grant_onehot = '0;
        o_grant_idx    = '0;
        w_found        = 1'b0;
        w_pos          = 0;
        w_pos_idx      = '0;
        for (int unsigned off = 0; off < N; off++) begin
            w_pos = 32'(i_ptr) + off;
            if (w_pos >= N) begin
                w_pos = w_pos - N;
            end
            w_pos_idx = PtrW'(w_pos);
            if (!w_found && !i_stall && i_req[w_pos_idx]) begin
                w_found                   = 1'b1;
                o_grant_onehot[w_pos_idx] = 1'b1;
                o_grant_idx               = w_pos_idx;
            end
        end
    end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter sharing the register-file write port; one registered write per cycle.
module regfile_write_arbiter
    import regfile_write_arbiter_pkg::*;
#(
    parameter int unsigned NREQ   = 3,
    parameter int unsigned DATA_W = 32
) (
    input  logic                     i_clock,
    input  logic                     i_reset_n,
    input  logic [NREQ-1:0]          i_req_valid,
    input  logic [REG_ADDR_W*NREQ-1:0] i_req_addr,
    input  logic [DATA_W*NREQ-1:0]   i_req_data,
    output logic [NREQ-1:0]          o_req_ready,
    input  logic                     i_stall,
    output logic                     o_wr_en,
    output logic [REG_ADDR_W-1:0]    o_wr_addr,
    output logic [DATA_W-1:0]        o_wr_data,
    output logic [NREQ-1:0]          o_last_grant
);

    localparam int unsigned PtrW = ptr_width(NREQ);

    logic [PtrW-1:0]   r_rr_ptr;
    logic [NREQ-1:0]   r_last_grant;
    logic              r_wr_en;
    reg_addr_t         r_wr_addr;
    logic [DATA_W-1:0] r_wr_data;

    logic [NREQ-1:0]   w_grant;
    logic [PtrW-1:0]   w_idx;
    logic              w_any;
    reg_addr_t         w_addr;
    logic [DATA_W-1:0] w_data;
    logic [PtrW-1:0]   w_ptr_next;

    // Holding reset through the picker keeps ready low while reset_n is asserted.
    rr_priority_pick #(
        .N    (NREQ),
        .PtrW (PtrW)
    ) u_pick (
        .i_req          (i_req_valid),
        .i_ptr          (r_rr_ptr),
        .i_stall        (i_stall | ~i_reset_n),
        .o_grant_onehot (w_grant),
        .o_grant_idx    (w_idx)
    );

    assign w_any      = |w_grant;
    assign w_addr     = i_req_addr[REG_ADDR_W*w_idx +: REG_ADDR_W];
    assign w_data     = i_req_data[DATA_W*w_idx +: DATA_W];
    assign w_ptr_next = (w_idx == PtrW'(NREQ - 1)) ? '0 : w_idx + PtrW'(1);

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_rr_ptr     <= '0;
            r_last_grant <= '0;
            r_wr_en      <= 1'b0;
            r_wr_addr    <= '0;
            r_wr_data    <= '0;
        end else if (w_any) begin
            r_rr_ptr     <= w_ptr_next;
            r_last_grant <= w_grant;
            // $r0 writes consume the grant but never reach the register file.
            r_wr_en      <= (w_addr != ZERO_REG);
            r_wr_addr    <= w_addr;
            r_wr_data    <= w_data;
        end else begin
            r_wr_en <= 1'b0;
        end
    end

    assign o_req_ready  = w_grant;
    assign o_wr_en      = r_wr_en;
    assign o_wr_addr    = r_wr_addr;
    assign o_wr_data    = r_wr_data;
    assign o_last_grant = r_last_grant;

endmodule
